pipelined_ripple_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder: a WIDTH-bit operand pair plus carry-in is split into STAGES equal slices, each slice rippled combinationally and its carry registered into the next stage. Operands enter and results leave through valid/ready handshakes with full backpressure. An optional mod-3 residue checker flags any result whose residue disagrees with the operands', giving a run-time detector for carry-chain tampering in the adder datapaths of our trojan-detection benchmark set.

---
 rtl/pipelined_ripple_adder_pkg.sv | 29 ++
 rtl/pipelined_ripple_adder_ripple_slice.sv | 29 ++
 rtl/pipelined_ripple_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_ripple_adder_pkg.sv
// pipelined_ripple_adder_pkg
//   Shared types and helpers for the pipelined ripple-carry adder:
//   - res_tag_t       : 2-bit mod-3 residue tag carried alongside each beat
//   - RES_MAX_W       : widest value mod3() accepts
//   - mod3()          : mod-3 residue of the low n bits of a value
//   - stages_divide() : elaboration check that WIDTH splits evenly into STAGES
package pipelined_ripple_adder_pkg;

    typedef logic [1:0] res_tag_t;

    localparam int unsigned RES_MAX_W = 64;

    // 2^i mod 3 alternates 1, 2, 1, 2, ..., so the residue is a weighted bit sum.
    function automatic res_tag_t mod3(input logic [RES_MAX_W-1:0] x, input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < RES_MAX_W; i++) begin
            if (i < n && x[i]) begin
                r = (r + (((i % 2) == 0) ? 1 : 2)) % 3;
            end
        end
        return res_tag_t'(r);
    endfunction

    function automatic bit stages_divide(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_ripple_adder_ripple_slice.sv
// ripple_slice
//   Combinational W-bit full-adder chain.
//   a, b : slice operands     cin  : carry into bit 0
//   s    : slice sum          cout : carry out of bit W-1
module ripple_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[W];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder
//   WIDTH-bit adder split into STAGES ripple slices with a register after
//   each slice; valid/ready on both sides with full backpressure.
//   clk, rst (sync, active-high)
//   a, b, cin, in_valid / in_ready     : operand beat input
//   sum, cout, out_valid / out_ready   : result output (registered)
//   res_err, res_err_sticky            : mod-3 residue mismatch flags
//   Optional feature: define RESIDUE_CHECK_EN to build the residue checker;
//   otherwise res_err and res_err_sticky are tied low.
module pipelined_ripple_adder
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_err,
    output logic             res_err_sticky
);

    localparam int SLICE = WIDTH / STAGES;

    if (!stages_divide(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_ripple_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic                          advance;
    logic [STAGES:1]               vld_q;
    logic [STAGES:1]               carry_q;   // carry_q[k]: carry out of slice k-1
    logic [WIDTH-1:0]              ps_q  [1:STAGES];  // partial sum, low k*SLICE bits valid
    logic [WIDTH-1:0]              rem_a_q [1:STAGES]; // operand bits still to add, shifted down
    logic [WIDTH-1:0]              rem_b_q [1:STAGES];
    logic [STAGES-1:0][SLICE-1:0]  sl_a, sl_b, sl_s;
    logic [STAGES-1:0]             sl_ci, sl_co;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES];
    assign sum       = ps_q[STAGES];
    assign cout      = carry_q[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_first
            assign sl_a[k]  = a[SLICE-1:0];
            assign sl_b[k]  = b[SLICE-1:0];
            assign sl_ci[k] = cin;
        end else begin : g_rest
            assign sl_a[k]  = rem_a_q[k][SLICE-1:0];
            assign sl_b[k]  = rem_b_q[k][SLICE-1:0];
            assign sl_ci[k] = carry_q[k];
        end

        ripple_slice #(.W(SLICE)) u_slice (
            .a    (sl_a[k]),
            .b    (sl_b[k]),
            .cin  (sl_ci[k]),
            .s    (sl_s[k]),
            .cout (sl_co[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            carry_q <= '0;
            for (int unsigned k = 1; k <= STAGES; k++) begin
                ps_q[k]    <= '0;
                rem_a_q[k] <= '0;
                rem_b_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q[1]              <= in_valid;
            carry_q[1]            <= sl_co[0];
            ps_q[1]               <= '0;
            ps_q[1][SLICE-1:0]    <= sl_s[0];
            rem_a_q[1]            <= a >> SLICE;
            rem_b_q[1]            <= b >> SLICE;
            for (int unsigned k = 2; k <= STAGES; k++) begin
                vld_q[k]                        <= vld_q[k-1];
                carry_q[k]                      <= sl_co[k-1];
                ps_q[k]                         <= ps_q[k-1];
                ps_q[k][(k-1)*SLICE +: SLICE]   <= sl_s[k-1];
                rem_a_q[k]                      <= rem_a_q[k-1] >> SLICE;
                rem_b_q[k]                      <= rem_b_q[k-1] >> SLICE;
            end
        end
    end

`ifdef RESIDUE_CHECK_EN
    res_tag_t               tag_q [1:STAGES];
    res_tag_t               tag_in;
    logic [RES_MAX_W-1:0]   result_ext;

    assign tag_in = res_tag_t'((int'(mod3(RES_MAX_W'(a), WIDTH))
                               + int'(mod3(RES_MAX_W'(b), WIDTH))
                               + int'(cin)) % 3);
    assign result_ext = RES_MAX_W'({cout, sum});
    assign res_err    = out_valid && (mod3(result_ext, WIDTH + 1) != tag_q[STAGES]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 1; k <= STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else if (advance) begin
            tag_q[1] <= tag_in;
            for (int unsigned k = 2; k <= STAGES; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_err_sticky <= 1'b0;
        end else if (res_err) begin
            res_err_sticky <= 1'b1;
        end
    end
`else
    assign res_err        = 1'b0;
    assign res_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder
//   Self-checking bench: random and directed beats against an arithmetic
//   reference (a + b + cin as a WIDTH+1-bit number) kept in a FIFO.
//   Residue-checker scenario is built only when RESIDUE_CHECK_EN is defined.
module tb_pipelined_ripple_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
    logic         res_err;
    logic         res_err_sticky;

    int vectors = 0;
    int miscompares = 0;

    logic [W:0] expq [$];
    logic [W:0] want, got;
    logic       have_want, in_fire, out_fire;
    logic       o_rdy, o_ov, o_err, o_stk;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .cin            (cin),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sum            (sum),
        .cout           (cout),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .res_err        (res_err),
        .res_err_sticky (res_err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    endfunction

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    // Drive one cycle's inputs at the falling edge, capture outputs and the
    // handshake outcome of the coming rising edge, and keep the FIFO of
    // expected results in step with accepted beats.
    task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                         input logic tc, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        a         = ta;
        b         = tb2;
        cin       = tc;
        out_ready = ordy;
        #1;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        o_rdy     = in_ready;
        o_ov      = out_valid;
        got       = {cout, sum};
        o_err     = res_err;
        o_stk     = res_err_sticky;
        have_want = 1'b0;
        want      = '0;
        if (out_fire === 1'b1 && expq.size() > 0) begin
            want      = expq.pop_front();
            have_want = 1'b1;
        end
        if (in_fire === 1'b1) expq.push_back(model(ta, tb2, tc));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        expq.delete();
        vectors++;
        if (o_ov !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", o_ov); end
        vectors++;
        if (got !== '0) begin miscompares++; $display("FAIL reset_sum_cout: got %h want 0", got); end
        vectors++;
        if (o_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", o_rdy); end
        vectors++;
        if (o_err !== 1'b0 || o_stk !== 1'b0) begin
            miscompares++; $display("FAIL reset_res_err: got %b/%b want 0/0", o_err, o_stk);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] da [3];
        logic [W-1:0] db [3];
        logic         dc [3];
        logic [W:0]   dexp [3];
        da[0] = 16'h00FF; db[0] = 16'h0001; dc[0] = 1'b0; dexp[0] = 17'h00100;
        da[1] = 16'hFFFF; db[1] = 16'hFFFF; dc[1] = 1'b1; dexp[1] = 17'h1FFFF;
        da[2] = 16'hFFFF; db[2] = 16'h0000; dc[2] = 1'b1; dexp[2] = 17'h10000;
        for (int v = 0; v < 3; v++) begin
            drive(1'b1, da[v], db[v], dc[v], 1'b1);
            vectors++;
            if (in_fire !== 1'b1) begin miscompares++; $display("FAIL directed_accept[%0d]: in_ready %b want 1", v, o_rdy); end
            for (int i = 1; i <= S; i++) begin
                drive(1'b0, '0, '0, 1'b0, 1'b1);
                vectors++;
                if (o_ov !== (i == S)) begin
                    miscompares++; $display("FAIL directed_latency[%0d] cycle %0d: out_valid %b want %b", v, i, o_ov, (i == S));
                end
                if (i == S) begin
                    vectors++;
                    if (got !== dexp[v]) begin
                        miscompares++; $display("FAIL directed_sum[%0d]: got cout/sum %h want %h", v, got, dexp[v]);
                    end
                    vectors++;
                    if (o_err !== 1'b0 || o_stk !== 1'b0) begin
                        miscompares++; $display("FAIL directed_res_err[%0d]: got %b/%b want 0/0", v, o_err, o_stk);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8 + S; j++) begin
            if (j < 8) drive(1'b1, rnd(), rnd(), 1'($urandom), 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b1);
            vectors++;
            if (o_rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready cycle %0d: got %b want 1", j, o_rdy); end
            vectors++;
            if (o_ov !== (j >= S && j < S + 8)) begin
                miscompares++; $display("FAIL b2b_out_valid cycle %0d: got %b want %b", j, o_ov, (j >= S && j < S + 8));
            end
            if (out_fire === 1'b1) begin
                vectors++;
                if (!have_want || got !== want) begin
                    miscompares++; $display("FAIL b2b_result cycle %0d: got %h want %h (outstanding %b)", j, got, want, have_want);
                end
            end
        end
        vectors++;
        if (expq.size() != 0) begin miscompares++; $display("FAIL b2b_drain: %0d results missing, want 0", expq.size()); end
    endtask

    task automatic test_backpressure();
        logic [W:0] hold_want;
        for (int j = 0; j < S; j++) drive(1'b1, rnd(), rnd(), 1'($urandom), 1'b0);
        hold_want = expq[0];
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, rnd(), rnd(), 1'($urandom), 1'b0);
            vectors++;
            if (o_rdy !== 1'b0 || o_ov !== 1'b1) begin
                miscompares++; $display("FAIL stall_handshake cycle %0d: in_ready %b out_valid %b want 0 1", j, o_rdy, o_ov);
            end
            vectors++;
            if (got !== hold_want) begin
                miscompares++; $display("FAIL stall_hold cycle %0d: got %h want %h", j, got, hold_want);
            end
        end
        for (int j = 0; j < 6 + S + 1; j++) begin
            if (j < 6) drive(1'b1, rnd(), rnd(), 1'($urandom), 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_fire === 1'b1) begin
                vectors++;
                if (!have_want || got !== want) begin
                    miscompares++; $display("FAIL stall_resume cycle %0d: got %h want %h (outstanding %b)", j, got, want, have_want);
                end
            end
        end
        vectors++;
        if (expq.size() != 0) begin miscompares++; $display("FAIL stall_drain: %0d results missing, want 0", expq.size()); end
    endtask

    task automatic test_reset_inflight();
        for (int j = 0; j < 3; j++) drive(1'b1, rnd(), rnd(), 1'($urandom), 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        expq.delete();
        vectors++;
        if (o_ov !== 1'b0 || got !== '0 || o_rdy !== 1'b1) begin
            miscompares++; $display("FAIL flush_state: out_valid %b sum/cout %h in_ready %b want 0 0 1", o_ov, got, o_rdy);
        end
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            vectors++;
            if (o_ov !== 1'b0) begin miscompares++; $display("FAIL flush_stale cycle %0d: out_valid %b want 0", j, o_ov); end
        end
    endtask

`ifdef RESIDUE_CHECK_EN
    task automatic test_residue();
        logic c2;
        drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        c2 = dut.carry_q[2];
        force dut.carry_q[2] = ~c2;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        release dut.carry_q[2];
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        vectors++;
        if (o_ov !== 1'b1 || o_err !== 1'b1) begin
            miscompares++; $display("FAIL residue_detect: out_valid %b res_err %b want 1 1", o_ov, o_err);
        end
        for (int j = 0; j < 8 + S; j++) begin
            if (j < 8) drive(1'b1, rnd(), rnd(), 1'($urandom), 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b1);
            vectors++;
            if (o_err !== 1'b0 || o_stk !== 1'b1) begin
                miscompares++; $display("FAIL residue_clean cycle %0d: res_err %b sticky %b want 0 1", j, o_err, o_stk);
            end
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        expq.delete();
        vectors++;
        if (o_stk !== 1'b0) begin miscompares++; $display("FAIL residue_sticky_clear: got %b want 0", o_stk); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
`ifdef RESIDUE_CHECK_EN
        test_residue();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
